// File: rtl/lenet_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lenet_pkg                                                                  |
// | Shared types and constants for the lenet layer sequencer: layer and FSM    |
// | state enums, address widths, and the per-layer SRAM base address table.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lenet_pkg;

  localparam int NUM_LAYERS = 5;
  localparam int LAYER_W    = 3;
  localparam int ACT_AW     = 10;
  localparam int WGT_AW     = 16;
  localparam int SCALE_W    = 32;

  typedef enum logic [LAYER_W-1:0] {
    L_CONV1 = 3'd0,
    L_CONV2 = 3'd1,
    L_CONV3 = 3'd2,
    L_FC1   = 3'd3,
    L_FC2   = 3'd4
  } layer_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_e;

  typedef struct packed {
    logic [ACT_AW-1:0] act_in_base;
    logic [ACT_AW-1:0] act_out_base;
    logic [WGT_AW-1:0] weight_base;
  } layer_cfg_t;

  // Activation regions chain: each layer's output region is the next layer's input.
  localparam logic [ACT_AW-1:0] ACT_BASE_CONV1_IN = 10'd0;
  localparam logic [ACT_AW-1:0] ACT_BASE_CONV2_IN = 10'd256;
  localparam logic [ACT_AW-1:0] ACT_BASE_CONV3_IN = 10'd592;
  localparam logic [ACT_AW-1:0] ACT_BASE_FC1_IN   = 10'd692;
  localparam logic [ACT_AW-1:0] ACT_BASE_FC2_IN   = 10'd722;
  localparam logic [ACT_AW-1:0] ACT_BASE_FC2_OUT  = 10'd743;

  localparam logic [WGT_AW-1:0] WGT_BASE_CONV1 = 16'd0;
  localparam logic [WGT_AW-1:0] WGT_BASE_CONV2 = 16'd40;
  localparam logic [WGT_AW-1:0] WGT_BASE_CONV3 = 16'd640;
  localparam logic [WGT_AW-1:0] WGT_BASE_FC1   = 16'd12640;
  localparam logic [WGT_AW-1:0] WGT_BASE_FC2   = 16'd15160;

  // Base address lookup; unused codes fall back to the CONV1 entry.
  function automatic layer_cfg_t layer_cfg(input layer_e id);
    layer_cfg_t cfg;
    cfg = '{ACT_BASE_CONV1_IN, ACT_BASE_CONV2_IN, WGT_BASE_CONV1};
    case (id)
      L_CONV2: cfg = '{ACT_BASE_CONV2_IN, ACT_BASE_CONV3_IN, WGT_BASE_CONV2};
      L_CONV3: cfg = '{ACT_BASE_CONV3_IN, ACT_BASE_FC1_IN,   WGT_BASE_CONV3};
      L_FC1:   cfg = '{ACT_BASE_FC1_IN,   ACT_BASE_FC2_IN,   WGT_BASE_FC1};
      L_FC2:   cfg = '{ACT_BASE_FC2_IN,   ACT_BASE_FC2_OUT,  WGT_BASE_FC2};
      default: cfg = '{ACT_BASE_CONV1_IN, ACT_BASE_CONV2_IN, WGT_BASE_CONV1};
    endcase
    return cfg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lenet_layer_cfg_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lenet_layer_cfg_rom                                                        |
// | Combinational per-layer configuration lookup.                              |
// | Ports:                                                                     |
// |   layer_id              in   layer being configured                        |
// |   scale_conv1..fc2      in   latched requant scales, one per layer         |
// |   cfg_act_in_base       out  activation input region base                  |
// |   cfg_act_out_base      out  activation output region base                 |
// |   cfg_weight_base       out  weight region base                            |
// |   cfg_scale             out  scale for the selected layer                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lenet_layer_cfg_rom
  import lenet_pkg::*;
(
  input  logic [LAYER_W-1:0] layer_id,
  input  logic [SCALE_W-1:0] scale_conv1,
  input  logic [SCALE_W-1:0] scale_conv2,
  input  logic [SCALE_W-1:0] scale_conv3,
  input  logic [SCALE_W-1:0] scale_fc1,
  input  logic [SCALE_W-1:0] scale_fc2,
  output logic [ACT_AW-1:0]  cfg_act_in_base,
  output logic [ACT_AW-1:0]  cfg_act_out_base,
  output logic [WGT_AW-1:0]  cfg_weight_base,
  output logic [SCALE_W-1:0] cfg_scale
);

  layer_cfg_t w_entry;

  always_comb begin
    w_entry   = layer_cfg(layer_e'(layer_id));
    cfg_scale = scale_conv1;
    case (layer_e'(layer_id))
      L_CONV2: cfg_scale = scale_conv2;
      L_CONV3: cfg_scale = scale_conv3;
      L_FC1:   cfg_scale = scale_fc1;
      L_FC2:   cfg_scale = scale_fc2;
      default: cfg_scale = scale_conv1;
    endcase
  end

  assign cfg_act_in_base  = w_entry.act_in_base;
  assign cfg_act_out_base = w_entry.act_out_base;
  assign cfg_weight_base  = w_entry.weight_base;

endmodule
`default_nettype wire

// File: rtl/lenet_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lenet_layer_sequencer                                                      |
// | Steps the shared layer engine through CONV1, CONV2, CONV3, FC1, FC2.       |
// | Each layer gets one layer_start pulse with its addresses and scale, then   |
// | the sequencer waits for layer_done, timing the layer and guarding it with  |
// | a watchdog.                                                                |
// | Ports:                                                                     |
// |   clk, rst_n          clock, asynchronous active-low reset                 |
// |   compute_start       in   start request (honoured in IDLE/DONE/ERROR)     |
// |   compute_finish      out  level, network completed                        |
// |   compute_error       out  level, watchdog fired                           |
// |   busy                out  high while a layer is issued or running         |
// |   scale_*             in   per-layer requant scales, latched at start      |
// |   layer_start         out  one-cycle pulse to layer engine                 |
// |   layer_id            out  current layer (0=CONV1 .. 4=FC2)                |
// |   layer_done          in   one-cycle pulse from layer engine               |
// |   cfg_*               out  current layer configuration                     |
// |   perf_sel            in   layer select for cycle-count readout            |
// |   perf_cycles         out  cycles used by selected layer (0 for 5..7)      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lenet_layer_sequencer
  import lenet_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               compute_start,
  output logic               compute_finish,
  output logic               compute_error,
  output logic               busy,
  input  logic [SCALE_W-1:0] scale_CONV1,
  input  logic [SCALE_W-1:0] scale_CONV2,
  input  logic [SCALE_W-1:0] scale_CONV3,
  input  logic [SCALE_W-1:0] scale_FC1,
  input  logic [SCALE_W-1:0] scale_FC2,
  output logic               layer_start,
  output logic [LAYER_W-1:0] layer_id,
  input  logic               layer_done,
  output logic [ACT_AW-1:0]  cfg_act_in_base,
  output logic [ACT_AW-1:0]  cfg_act_out_base,
  output logic [WGT_AW-1:0]  cfg_weight_base,
  output logic [SCALE_W-1:0] cfg_scale,
  input  logic [LAYER_W-1:0] perf_sel,
  output logic [CNT_W-1:0]   perf_cycles
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_e             r_state;
  state_e             w_state_nxt;
  layer_e             r_layer_id;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [CNT_W-1:0]   r_perf  [NUM_LAYERS];
  logic [SCALE_W-1:0] r_scale [NUM_LAYERS];
  logic               w_accept;
  logic               w_last_layer;
  logic               w_timeout;

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_last_layer = (r_layer_id == L_FC2);
  assign w_timeout    = (r_cnt >= TIMEOUT_VAL);
  assign layer_id     = r_layer_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    busy           = 1'b0;
    layer_start    = 1'b0;
    compute_finish = 1'b0;
    compute_error  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (compute_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy        = 1'b1;
        layer_start = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        // A done arriving on the timeout cycle still completes the layer.
        if (layer_done) begin
          w_state_nxt = w_last_layer ? S_DONE : S_ISSUE;
        end else if (w_timeout) begin
          w_state_nxt = S_ERROR;
        end
      end
      S_DONE: begin
        compute_finish = 1'b1;
        if (compute_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ERROR: begin
        compute_error = 1'b1;
        if (compute_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_layer_id <= L_CONV1;
      r_cnt      <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_perf[i]  <= '0;
        r_scale[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_layer_id <= L_CONV1;
        r_scale[0] <= scale_CONV1;
        r_scale[1] <= scale_CONV2;
        r_scale[2] <= scale_CONV3;
        r_scale[3] <= scale_FC1;
        r_scale[4] <= scale_FC2;
        for (int i = 0; i < NUM_LAYERS; i++) begin
          r_perf[i] <= '0;
        end
      end
      case (r_state)
        // Counting starts at 1 so the stored figure covers the ISSUE cycle too.
        S_ISSUE: r_cnt <= CNT_W'(1);
        S_WAIT: begin
          if (layer_done) begin
            r_perf[r_layer_id] <= w_cnt_inc;
            if (!w_last_layer) begin
              r_layer_id <= layer_e'(r_layer_id + 3'd1);
            end
          end else if (w_timeout) begin
            r_perf[r_layer_id] <= TIMEOUT_VAL;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    perf_cycles = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (perf_sel == LAYER_W'(i)) begin
        perf_cycles = r_perf[i];
      end
    end
  end

  lenet_layer_cfg_rom u_cfg_rom (
    .layer_id         (r_layer_id),
    .scale_conv1      (r_scale[0]),
    .scale_conv2      (r_scale[1]),
    .scale_conv3      (r_scale[2]),
    .scale_fc1        (r_scale[3]),
    .scale_fc2        (r_scale[4]),
    .cfg_act_in_base  (cfg_act_in_base),
    .cfg_act_out_base (cfg_act_out_base),
    .cfg_weight_base  (cfg_weight_base),
    .cfg_scale        (cfg_scale)
  );

endmodule
`default_nettype wire

// File: tb/tb_lenet_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lenet_layer_sequencer                                                   |
// | Directed bench: instance 0 uses the default watchdog, instance 1 uses a    |
// | 50-cycle watchdog. A small engine model answers each layer_start.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lenet_layer_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cs   [2];
  logic        ld   [2];
  logic        fin  [2];
  logic        err  [2];
  logic        bsy  [2];
  logic        ls   [2];
  logic [2:0]  lid  [2];
  logic [9:0]  cin  [2];
  logic [9:0]  cout [2];
  logic [15:0] cw   [2];
  logic [31:0] csc  [2];
  logic [31:0] perf [2];
  logic [31:0] sc   [5];
  logic [2:0]  perf_sel;

  lenet_layer_sequencer #(.TIMEOUT_CYCLES(20000), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .compute_start(cs[0]),
    .compute_finish(fin[0]), .compute_error(err[0]), .busy(bsy[0]),
    .scale_CONV1(sc[0]), .scale_CONV2(sc[1]), .scale_CONV3(sc[2]),
    .scale_FC1(sc[3]), .scale_FC2(sc[4]),
    .layer_start(ls[0]), .layer_id(lid[0]), .layer_done(ld[0]),
    .cfg_act_in_base(cin[0]), .cfg_act_out_base(cout[0]),
    .cfg_weight_base(cw[0]), .cfg_scale(csc[0]),
    .perf_sel(perf_sel), .perf_cycles(perf[0])
  );

  lenet_layer_sequencer #(.TIMEOUT_CYCLES(50), .CNT_W(32)) dut_wd (
    .clk(clk), .rst_n(rst_n), .compute_start(cs[1]),
    .compute_finish(fin[1]), .compute_error(err[1]), .busy(bsy[1]),
    .scale_CONV1(sc[0]), .scale_CONV2(sc[1]), .scale_CONV3(sc[2]),
    .scale_FC1(sc[3]), .scale_FC2(sc[4]),
    .layer_start(ls[1]), .layer_id(lid[1]), .layer_done(ld[1]),
    .cfg_act_in_base(cin[1]), .cfg_act_out_base(cout[1]),
    .cfg_weight_base(cw[1]), .cfg_scale(csc[1]),
    .perf_sel(perf_sel), .perf_cycles(perf[1])
  );

  typedef struct {
    int          lat;
    logic [9:0]  in_b;
    logic [9:0]  out_b;
    logic [15:0] wgt;
    logic [31:0] scale;
  } lvec_t;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] exp_perf;
  } pvec_t;

  lvec_t lv [5];
  pvec_t pv [8];

  int checks = 0;
  int errors = 0;
  int n_starts = 0;

  always @(negedge clk) if (ls[0]) n_starts++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start(input int d);
    @(posedge clk); #1 cs[d] = 1'b1;
    @(posedge clk); #1 cs[d] = 1'b0;
  endtask

  // Returns at the negedge of the cycle in which layer_start is seen.
  task automatic wait_start(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (ls[d]) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_start[%0d]: got no layer_start expected layer_start within 20 cycles", d);
    end
  endtask

  // Engine model: layer_done is high in cycle T+lat where T is the start cycle.
  task automatic do_layer(input int d, input int lat, input bit poke, input bit chg);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      ld[d] = (c == lat);
      cs[d] = poke && (c == 5);
      if (chg && c == 3) sc[2] = 32'd0;
    end
    @(negedge clk);
    check("finish_low_on_done", {31'd0, fin[d]}, 32'd0);
    @(posedge clk); #1 ld[d] = 1'b0; cs[d] = 1'b0;
  endtask

  task automatic run_full(input bit poke, input bit chg);
    bit ok;
    int s0;
    s0 = n_starts;
    pulse_start(0);
    for (int l = 0; l < 5; l++) begin
      wait_start(0, ok);
      if (!ok) break;
      check("layer_id", {29'd0, lid[0]}, l);
      check("cfg_in_base", {22'd0, cin[0]}, {22'd0, lv[l].in_b});
      check("cfg_out_base", {22'd0, cout[0]}, {22'd0, lv[l].out_b});
      check("cfg_weight_base", {16'd0, cw[0]}, {16'd0, lv[l].wgt});
      check("cfg_scale", csc[0], lv[l].scale);
      do_layer(0, lv[l].lat, poke && l == 1, chg && l == 0);
    end
    @(negedge clk);
    check("finish_after_fc2", {31'd0, fin[0]}, 32'd1);
    check("error_after_fc2", {31'd0, err[0]}, 32'd0);
    check("busy_after_fc2", {31'd0, bsy[0]}, 32'd0);
    repeat (5) @(negedge clk);
    check("start_count", n_starts - s0, 32'd5);
    check("finish_held", {31'd0, fin[0]}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      perf_sel = pv[i].sel;
      #1;
      check("perf_readout", perf[0], pv[i].exp_perf);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish before 300000");
    $fatal(1, "bench stalled");
  end

  initial begin
    bit ok;
    lv[0] = '{100, 10'd0,   10'd256, 16'd0,     32'd102};
    lv[1] = '{200, 10'd256, 10'd592, 16'd40,    32'd187};
    lv[2] = '{300, 10'd592, 10'd692, 16'd640,   32'd175};
    lv[3] = '{50,  10'd692, 10'd722, 16'd12640, 32'd416};
    lv[4] = '{20,  10'd722, 10'd743, 16'd15160, 32'd381};
    pv[0] = '{3'd0, 32'd101};
    pv[1] = '{3'd1, 32'd201};
    pv[2] = '{3'd2, 32'd301};
    pv[3] = '{3'd3, 32'd51};
    pv[4] = '{3'd4, 32'd21};
    pv[5] = '{3'd5, 32'd0};
    pv[6] = '{3'd6, 32'd0};
    pv[7] = '{3'd7, 32'd0};

    rst_n = 1'b0;
    cs[0] = 1'b0; cs[1] = 1'b0; ld[0] = 1'b0; ld[1] = 1'b0;
    perf_sel = 3'd0;
    for (int i = 0; i < 5; i++) sc[i] = lv[i].scale;

    // Reset values: scales are not latched until a start is accepted.
    repeat (3) @(negedge clk);
    check("rst_finish", {31'd0, fin[0]}, 32'd0);
    check("rst_error", {31'd0, err[0]}, 32'd0);
    check("rst_busy", {31'd0, bsy[0]}, 32'd0);
    check("rst_layer_start", {31'd0, ls[0]}, 32'd0);
    check("rst_layer_id", {29'd0, lid[0]}, 32'd0);
    check("rst_cfg_out", {22'd0, cout[0]}, 32'd256);
    check("rst_cfg_scale", csc[0], 32'd0);
    for (int i = 0; i < 5; i++) begin
      perf_sel = 3'(i);
      #1;
      check("rst_perf", perf[0], 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // Stray layer_done in IDLE.
    @(posedge clk); #1 ld[0] = 1'b1;
    @(posedge clk); #1 ld[0] = 1'b0;
    perf_sel = 3'd0;
    @(negedge clk);
    check("idle_done_busy", {31'd0, bsy[0]}, 32'd0);
    check("idle_done_start", {31'd0, ls[0]}, 32'd0);
    check("idle_done_finish", {31'd0, fin[0]}, 32'd0);
    check("idle_done_perf", perf[0], 32'd0);

    // Nominal run, then a run with a busy start poke and a late scale change.
    run_full(1'b0, 1'b0);
    run_full(1'b1, 1'b1);
    sc[2] = 32'd175;

    // Watchdog on the 50-cycle instance.
    pulse_start(1);
    wait_start(1, ok); do_layer(1, 10, 1'b0, 1'b0);
    wait_start(1, ok); do_layer(1, 10, 1'b0, 1'b0);
    wait_start(1, ok);
    check("wd_layer_id", {29'd0, lid[1]}, 32'd2);
    repeat (49) @(negedge clk);
    check("wd_no_error_early", {31'd0, err[1]}, 32'd0);
    check("wd_busy_early", {31'd0, bsy[1]}, 32'd1);
    repeat (2) @(negedge clk);
    check("wd_error", {31'd0, err[1]}, 32'd1);
    check("wd_finish", {31'd0, fin[1]}, 32'd0);
    check("wd_busy", {31'd0, bsy[1]}, 32'd0);
    perf_sel = 3'd2; #1;
    check("wd_perf2", perf[1], 32'd50);
    perf_sel = 3'd0; #1;
    check("wd_perf0", perf[1], 32'd11);
    repeat (4) @(negedge clk);
    check("wd_error_held", {31'd0, err[1]}, 32'd1);

    // Restart after error; CONV1 done lands exactly on the timeout cycle.
    pulse_start(1);
    wait_start(1, ok);
    check("wd_restart_id", {29'd0, lid[1]}, 32'd0);
    check("wd_restart_error", {31'd0, err[1]}, 32'd0);
    check("wd_restart_perf", perf[1], 32'd0);
    do_layer(1, 50, 1'b0, 1'b0);
    @(negedge clk);
    check("tie_no_error", {31'd0, err[1]}, 32'd0);
    check("tie_next_layer", {29'd0, lid[1]}, 32'd1);
    check("tie_perf0", perf[1], 32'd51);
    for (int l = 1; l < 5; l++) begin
      if (l > 1) wait_start(1, ok);
      do_layer(1, 10, 1'b0, 1'b0);
    end
    @(negedge clk);
    check("tie_finish", {31'd0, fin[1]}, 32'd1);
    check("tie_error_final", {31'd0, err[1]}, 32'd0);

    // Reset during FC1 WAIT on the main instance.
    pulse_start(0);
    for (int l = 0; l < 3; l++) begin
      wait_start(0, ok);
      do_layer(0, 5, 1'b0, 1'b0);
    end
    wait_start(0, ok);
    check("mid_reached_fc1", {29'd0, lid[0]}, 32'd3);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0; perf_sel = 3'd0;
    #2;
    check("mid_rst_busy", {31'd0, bsy[0]}, 32'd0);
    check("mid_rst_start", {31'd0, ls[0]}, 32'd0);
    check("mid_rst_finish", {31'd0, fin[0]}, 32'd0);
    check("mid_rst_error", {31'd0, err[0]}, 32'd0);
    check("mid_rst_layer_id", {29'd0, lid[0]}, 32'd0);
    check("mid_rst_perf", perf[0], 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_full(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
